// File: rtl/sha256d_nonce_feeder.sv
// Nonce-scanning sequencer for a SHA-256 block core: midstate once per go, then
// SHA-256d per nonce with a target compare on the byte-reversed digest.
module sha256d_nonce_feeder #(
  parameter logic [255:0] SHA_IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter bit           STOP_ON_FOUND = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic         stop,
  input  logic [607:0] hdr_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target_in,
  output logic         sha_start,
  input  logic         sha_rq,
  input  logic [3:0]   sha_addr,
  output logic         sha_rdy,
  output logic [31:0]  sha_data,
  output logic [255:0] sha_state_in,
  input  logic [255:0] sha_state_out,
  input  logic         sha_done,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         exhausted
);
  typedef enum logic [2:0] {
    S_IDLE, S_MID_GO, S_MID_WAIT, S_C2_GO, S_C2_WAIT, S_H2_GO, S_H2_WAIT, S_CHECK
  } state_e;

  state_e            state_q, state_d;
  logic [0:18][31:0] hdr_q;
  logic [31:0]       nonce_q, nonce_d, nonce_end_q;
  logic [255:0]      target_q, midstate_q, digest2_q;
  logic [0:7][31:0]  digest1_q;
  logic              stop_q, stop_d;
  logic              rdy_q, rdy_d;
  logic [31:0]       data_q, word;
  logic              found_q, found_d, exh_q, exh_d, load;
  logic [31:0]       fnonce_q;
  logic [255:0]      fhash_q, hash_le;
  logic              in_wait, hit;

  assign in_wait = (state_q == S_MID_WAIT) || (state_q == S_C2_WAIT) || (state_q == S_H2_WAIT);

  always_comb begin
    hash_le = '0;
    for (int i = 0; i < 32; i++) hash_le[8*i +: 8] = digest2_q[255-8*i -: 8];
  end
  assign hit = (hash_le <= target_q);

  // Word source for the current pass; padding constants encode 640- and 256-bit messages.
  always_comb begin
    word = 32'h0;
    case (state_q)
      S_MID_WAIT: word = hdr_q[5'(sha_addr)];
      S_C2_WAIT: begin
        if (sha_addr < 4'd3)        word = hdr_q[5'(sha_addr) + 5'd16];
        else if (sha_addr == 4'd3)  word = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
        else if (sha_addr == 4'd4)  word = 32'h80000000;
        else if (sha_addr == 4'd15) word = 32'h00000280;
      end
      S_H2_WAIT: begin
        if (!sha_addr[3])           word = digest1_q[sha_addr[2:0]];
        else if (sha_addr == 4'd8)  word = 32'h80000000;
        else if (sha_addr == 4'd15) word = 32'h00000100;
      end
      default: word = 32'h0;
    endcase
  end

  assign rdy_d = in_wait && !sha_done && sha_rq && !rdy_q;

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    found_d = 1'b0;
    exh_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        load    = 1'b1;
        nonce_d = nonce_start;
        state_d = S_MID_GO;
      end
      S_MID_GO:   state_d = S_MID_WAIT;
      S_MID_WAIT: if (sha_done) state_d = S_C2_GO;
      S_C2_GO:    state_d = S_C2_WAIT;
      S_C2_WAIT:  if (sha_done) state_d = S_H2_GO;
      S_H2_GO:    state_d = S_H2_WAIT;
      S_H2_WAIT:  if (sha_done) state_d = S_CHECK;
      S_CHECK: begin
        found_d = hit;
        if (hit && STOP_ON_FOUND)      state_d = S_IDLE;
        else if (stop_q)               state_d = S_IDLE;
        else if (nonce_q == nonce_end_q) begin
          exh_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          nonce_d = nonce_q + 32'd1;
          state_d = S_C2_GO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stop is only remembered while scanning; anything seen in IDLE is dropped.
  assign stop_d = (state_d == S_IDLE) ? 1'b0 : (stop_q || (stop && state_q != S_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
      midstate_q  <= '0;
      digest1_q   <= '0;
      digest2_q   <= '0;
      stop_q      <= 1'b0;
      rdy_q       <= 1'b0;
      data_q      <= '0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
      fnonce_q    <= '0;
      fhash_q     <= '0;
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      stop_q  <= stop_d;
      rdy_q   <= rdy_d;
      found_q <= found_d;
      exh_q   <= exh_d;
      if (rdy_d) data_q <= word;
      if (load) begin
        hdr_q       <= hdr_in;
        nonce_end_q <= nonce_end;
        target_q    <= target_in;
      end
      if (state_q == S_MID_WAIT && sha_done) midstate_q <= sha_state_out;
      if (state_q == S_C2_WAIT && sha_done)  digest1_q  <= sha_state_out;
      if (state_q == S_H2_WAIT && sha_done)  digest2_q  <= sha_state_out;
      if (found_d) begin
        fnonce_q <= nonce_q;
        fhash_q  <= hash_le;
      end
    end
  end

  assign sha_start    = (state_q == S_MID_GO) || (state_q == S_C2_GO) || (state_q == S_H2_GO);
  assign sha_state_in = (state_q == S_C2_GO || state_q == S_C2_WAIT) ? midstate_q : SHA_IV;
  assign sha_rdy      = rdy_q;
  assign sha_data     = data_q;
  assign busy         = (state_q != S_IDLE);
  assign found        = found_q;
  assign exhausted    = exh_q;
  assign found_nonce  = fnonce_q;
  assign found_hash   = fhash_q;
endmodule

// File: tb/tb_sha256d_nonce_feeder.sv
// Directed bench: behavioural SHA-256 block core on the word bus, genesis-block SHA-256d scan.
module tb_sha256d_nonce_feeder;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [607:0] GEN_HDR = {32'h01000000, 256'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] GEN_TGT  = 256'hffff << 208;
  localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  typedef logic [0:15][31:0] blk_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic go = 1'b0, stop = 1'b0;
  logic [607:0] hdr_in = '0;
  logic [31:0] nonce_start = '0, nonce_end = '0;
  logic [255:0] target_in = '0;
  logic sha_start, sha_rq, sha_rdy, sha_done, busy, found, exhausted;
  logic [3:0] sha_addr;
  logic [31:0] sha_data, found_nonce;
  logic [255:0] sha_state_in, sha_state_out, found_hash;

  int n_cmp = 0, n_bad = 0;
  int n_start = 0, n_found = 0, n_exh = 0, prot_err = 0, si_err = 0;

  always #5 clk = ~clk;

  sha256d_nonce_feeder dut (
    .clk(clk), .rst_n(rst_n), .go(go), .stop(stop), .hdr_in(hdr_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target_in(target_in),
    .sha_start(sha_start), .sha_rq(sha_rq), .sha_addr(sha_addr), .sha_rdy(sha_rdy),
    .sha_data(sha_data), .sha_state_in(sha_state_in), .sha_state_out(sha_state_out),
    .sha_done(sha_done), .busy(busy), .found(found), .found_nonce(found_nonce),
    .found_hash(found_hash), .exhausted(exhausted));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] st, input blk_t blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  // Core model: latch state_in at start, fetch 16 words one request at a time, then compress.
  typedef enum logic [1:0] {C_IDLE, C_REQ, C_CALC, C_DONE} cst_e;
  cst_e cs;
  logic [3:0] ck;
  blk_t cblk;
  logic [255:0] cst;
  blk_t blk_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs <= C_IDLE; ck <= '0; sha_rq <= 1'b0; sha_done <= 1'b0; sha_state_out <= '0;
    end else begin
      case (cs)
        C_IDLE: if (sha_start) begin cst <= sha_state_in; ck <= '0; sha_rq <= 1'b1; cs <= C_REQ; end
        C_REQ: if (sha_rdy) begin
          cblk[ck] <= sha_data;
          if (ck == 4'd15) begin sha_rq <= 1'b0; cs <= C_CALC; end
          else ck <= ck + 4'd1;
        end
        C_CALC: begin
          sha_state_out <= sha_comp(cst, cblk);
          sha_done <= 1'b1;
          blk_log.push_back(cblk);
          cs <= C_DONE;
        end
        default: begin sha_done <= 1'b0; cs <= C_IDLE; end
      endcase
    end
  end
  assign sha_addr = ck;

  logic p_rq = 1'b0, p_rdy = 1'b0;
  logic [255:0] si_ref = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_rq <= 1'b0; p_rdy <= 1'b0;
    end else begin
      if (sha_start) n_start <= n_start + 1;
      if (found) n_found <= n_found + 1;
      if (exhausted) n_exh <= n_exh + 1;
      if (sha_rdy !== (p_rq & ~p_rdy)) prot_err <= prot_err + 1;
      if (sha_start) si_ref <= sha_state_in;
      else if (cs != C_IDLE && sha_state_in !== si_ref) si_err <= si_err + 1;
      p_rq <= sha_rq; p_rdy <= sha_rdy;
    end
  end

  task automatic launch(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt);
    @(negedge clk);
    hdr_in = GEN_HDR; nonce_start = ns; nonce_end = ne; target_in = tgt; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input int cnt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (n_start >= cnt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (sha_start !== 1'b0 || sha_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_bus got start=%0b rdy=%0b want 0/0", sha_start, sha_rdy); end
    n_cmp++; if (found !== 1'b0 || exhausted !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %0b/%0b want 0/0", found, exhausted); end
    n_cmp++; if (sha_data !== 32'h0 || found_nonce !== 32'h0 || found_hash !== 256'h0) begin n_bad++; $display("FAIL reset_data got %h/%h/%h want zeros", sha_data, found_nonce, found_hash); end
    n_cmp++; if (sha_state_in !== IV) begin n_bad++; $display("FAIL reset_state_in got %h want %h", sha_state_in, IV); end
  endtask

  task automatic test_genesis(input string tag, input int f0, input int e0, input int s0);
    bit ok;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout got busy=%0b want 0", tag, busy); end
    n_cmp++; if (n_found - f0 !== 1) begin n_bad++; $display("FAIL %s_found_cnt got %0d want 1", tag, n_found - f0); end
    n_cmp++; if (found_nonce !== 32'h7C2BAC1D) begin n_bad++; $display("FAIL %s_nonce got %h want 7c2bac1d", tag, found_nonce); end
    n_cmp++; if (found_hash !== GEN_HASH) begin n_bad++; $display("FAIL %s_hash got %h want %h", tag, found_hash, GEN_HASH); end
    n_cmp++; if (n_exh - e0 !== 0) begin n_bad++; $display("FAIL %s_exh_cnt got %0d want 0", tag, n_exh - e0); end
    n_cmp++; if (n_start - s0 !== 7) begin n_bad++; $display("FAIL %s_starts got %0d want 7", tag, n_start - s0); end
  endtask

  task automatic test_genesis_scan;
    int f0, e0, s0, b0;
    blk_t blk;
    f0 = n_found; e0 = n_exh; s0 = n_start; b0 = blk_log.size();
    launch(32'h7C2BAC1B, 32'h7C2BAC20, GEN_TGT);
    test_genesis("t1", f0, e0, s0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after got %0b want 0", busy); end
    blk = blk_log[b0 + 1];
    n_cmp++; if (blk[3] !== 32'h1BAC2B7C || blk[4] !== 32'h80000000 || blk[15] !== 32'h00000280)
      begin n_bad++; $display("FAIL t6_c2_words got %h/%h/%h want 1bac2b7c/80000000/00000280", blk[3], blk[4], blk[15]); end
    blk = blk_log[b0 + 2];
    n_cmp++; if (blk[8] !== 32'h80000000 || blk[9] !== 32'h0 || blk[15] !== 32'h00000100)
      begin n_bad++; $display("FAIL t6_h2_words got %h/%h/%h want 80000000/0/00000100", blk[8], blk[9], blk[15]); end
  endtask

  task automatic test_no_hit;
    int f0, e0, s0;
    bit ok;
    f0 = n_found; e0 = n_exh; s0 = n_start;
    launch(32'h10, 32'h14, 256'h0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t2_timeout got busy=%0b want 0", busy); end
    n_cmp++; if (n_exh - e0 !== 1) begin n_bad++; $display("FAIL t2_exh_cnt got %0d want 1", n_exh - e0); end
    n_cmp++; if (n_found - f0 !== 0) begin n_bad++; $display("FAIL t2_found_cnt got %0d want 0", n_found - f0); end
    n_cmp++; if (n_start - s0 !== 11) begin n_bad++; $display("FAIL t2_starts got %0d want 11", n_start - s0); end
  endtask

  task automatic test_wrap;
    int e0, b0;
    bit ok;
    blk_t blk;
    logic [31:0] exp_w3 [4];
    exp_w3 = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};
    e0 = n_exh; b0 = blk_log.size();
    launch(32'hFFFFFFFE, 32'h00000001, 256'h0);
    wait_idle(ok);
    n_cmp++; if (!ok || blk_log.size() - b0 !== 9) begin n_bad++; $display("FAIL t3_blocks got %0d want 9", blk_log.size() - b0); end
    else for (int i = 0; i < 4; i++) begin
      blk = blk_log[b0 + 1 + 2*i];
      n_cmp++; if (blk[3] !== exp_w3[i]) begin n_bad++; $display("FAIL t3_nonce%0d got %h want %h", i, blk[3], exp_w3[i]); end
    end
    n_cmp++; if (n_exh - e0 !== 1) begin n_bad++; $display("FAIL t3_exh_cnt got %0d want 1", n_exh - e0); end
  endtask

  task automatic test_stop;
    int f0, e0, s0;
    bit ok;
    f0 = n_found; e0 = n_exh; s0 = n_start;
    launch(32'h0, 32'h100, 256'h0);
    wait_starts(s0 + 3, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_h2_timeout got starts=%0d want 3", n_start - s0); end
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_timeout got busy=%0b want 0", busy); end
    n_cmp++; if (n_start - s0 !== 3) begin n_bad++; $display("FAIL t4_starts got %0d want 3", n_start - s0); end
    n_cmp++; if (n_found - f0 !== 0 || n_exh - e0 !== 0) begin n_bad++; $display("FAIL t4_pulses got %0d/%0d want 0/0", n_found - f0, n_exh - e0); end
  endtask

  task automatic test_single_after_idle_stop;
    int e0, s0;
    bit ok;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    e0 = n_exh; s0 = n_start;
    launch(32'h5, 32'h5, 256'h0);
    wait_idle(ok);
    n_cmp++; if (!ok || n_exh - e0 !== 1) begin n_bad++; $display("FAIL single_exh got %0d want 1", n_exh - e0); end
    n_cmp++; if (n_start - s0 !== 3) begin n_bad++; $display("FAIL single_starts got %0d want 3", n_start - s0); end
  endtask

  task automatic test_reset_mid;
    int f0, e0, s0;
    bit ok;
    s0 = n_start;
    launch(32'h7C2BAC1B, 32'h7C2BAC20, GEN_TGT);
    wait_starts(s0 + 2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t5_c2_timeout got starts=%0d want 2", n_start - s0); end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || sha_start !== 1'b0 || sha_rdy !== 1'b0 || sha_data !== 32'h0)
      begin n_bad++; $display("FAIL t5_bus got busy=%0b start=%0b rdy=%0b data=%h want zeros", busy, sha_start, sha_rdy, sha_data); end
    n_cmp++; if (found_nonce !== 32'h0 || found_hash !== 256'h0 || found !== 1'b0 || exhausted !== 1'b0)
      begin n_bad++; $display("FAIL t5_result got %h/%h want zeros", found_nonce, found_hash); end
    n_cmp++; if (sha_state_in !== IV) begin n_bad++; $display("FAIL t5_state_in got %h want %h", sha_state_in, IV); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = n_found; e0 = n_exh; s0 = n_start;
    launch(32'h7C2BAC1B, 32'h7C2BAC20, GEN_TGT);
    test_genesis("t5", f0, e0, s0);
  endtask

  task automatic test_protocol;
    n_cmp++; if (prot_err !== 0) begin n_bad++; $display("FAIL t6_rdy_timing got %0d violations want 0", prot_err); end
    n_cmp++; if (si_err !== 0) begin n_bad++; $display("FAIL t6_state_in_stable got %0d changes want 0", si_err); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_genesis_scan;
    test_no_hit;
    test_wrap;
    test_stop;
    test_single_after_idle_stop;
    test_reset_mid;
    test_protocol;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
